// File: rtl/mem_arbiter.sv
// Two-master arbiter for a single-port memory: bounded-burst round-robin grant,
// combinational request-cycle muxing and a fixed-latency read response router.
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int MAX_BURST    = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [DATA_W-1:0] m0_rdata_o,

    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [DATA_W-1:0] m1_rdata_o,

    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {
        OWNER_M0 = 1'b0,
        OWNER_M1 = 1'b1
    } owner_e;

    owner_e            last_owner_q, last_owner_d;
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;

    logic [READ_LATENCY-1:0] rsp_valid_q, rsp_valid_d;
    logic [READ_LATENCY-1:0] rsp_id_q, rsp_id_d;

    logic   gnt0, gnt1, any_gnt;
    owner_e gnt_id;

    // ------------------------------------------------------------------
    // Grant selection; everything is forced low while reset is asserted.
    // ------------------------------------------------------------------
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_ni) begin
            if (m0_req_i && !m1_req_i) begin
                gnt0 = 1'b1;
            end else if (m1_req_i && !m0_req_i) begin
                gnt1 = 1'b1;
            end else if (m0_req_i && m1_req_i) begin
                if (burst_cnt_q == '0) begin
                    gnt0 = 1'b1;
                end else if (burst_cnt_q < CNT_MAX) begin
                    gnt0 = (last_owner_q == OWNER_M0);
                    gnt1 = (last_owner_q == OWNER_M1);
                end else begin
                    gnt0 = (last_owner_q == OWNER_M1);
                    gnt1 = (last_owner_q == OWNER_M0);
                end
            end
        end
    end

    assign any_gnt = gnt0 | gnt1;
    assign gnt_id  = gnt1 ? OWNER_M1 : OWNER_M0;

    assign m0_gnt_o  = gnt0;
    assign m1_gnt_o  = gnt1;
    assign mem_req_o = any_gnt;

    always_comb begin
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (gnt0) begin
            mem_we_o    = m0_we_i;
            mem_addr_o  = m0_addr_i;
            mem_wdata_o = m0_wdata_i;
        end else if (gnt1) begin
            mem_we_o    = m1_we_i;
            mem_addr_o  = m1_addr_i;
            mem_wdata_o = m1_wdata_i;
        end
    end

    // ------------------------------------------------------------------
    // Burst tracking: count saturates so a waiting master is served next.
    // ------------------------------------------------------------------
    always_comb begin
        last_owner_d = last_owner_q;
        burst_cnt_d  = '0;
        if (any_gnt) begin
            if (gnt_id == last_owner_q) begin
                burst_cnt_d = (burst_cnt_q == CNT_MAX) ? burst_cnt_q
                                                        : burst_cnt_q + CNT_ONE;
            end else begin
                last_owner_d = gnt_id;
                burst_cnt_d  = CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Response pipeline: stage 0 captures the issue, last stage is output.
    // ------------------------------------------------------------------
    assign rsp_valid_d[0] = any_gnt & ~mem_we_o;
    assign rsp_id_d[0]    = any_gnt & ~mem_we_o & (gnt_id == OWNER_M1);

    generate
        for (genvar gi = 1; gi < READ_LATENCY; gi++) begin : g_rsp_stage
            assign rsp_valid_d[gi] = rsp_valid_q[gi-1];
            assign rsp_id_d[gi]    = rsp_id_q[gi-1];
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_owner_q <= OWNER_M0;
            burst_cnt_q  <= '0;
            rsp_valid_q  <= '0;
            rsp_id_q     <= '0;
        end else begin
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
        end
    end

    logic out_valid, out_id;
    assign out_valid = rst_ni & rsp_valid_q[READ_LATENCY-1];
    assign out_id    = rsp_id_q[READ_LATENCY-1];

    assign m0_rvalid_o = out_valid & ~out_id;
    assign m1_rvalid_o = out_valid & out_id;
    assign m0_rdata_o  = m0_rvalid_o ? mem_rdata_i : '0;
    assign m1_rdata_o  = m1_rvalid_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at read latency 1, one at latency 2,
// both driven by the same master stimulus.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [31:0] mem_rdata;

    logic        a_m0_gnt, a_m0_rvalid, a_m1_gnt, a_m1_rvalid;
    logic [31:0] a_m0_rdata, a_m1_rdata;
    logic        a_mem_req, a_mem_we;
    logic [31:0] a_mem_addr, a_mem_wdata;

    logic        b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid;
    logic [31:0] b_m0_rdata, b_m1_rdata;
    logic        b_mem_req, b_mem_we;
    logic [31:0] b_mem_addr, b_mem_wdata;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(1), .MAX_BURST(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_gnt_o(a_m0_gnt), .m0_rvalid_o(a_m0_rvalid), .m0_rdata_o(a_m0_rdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m1_gnt_o(a_m1_gnt), .m1_rvalid_o(a_m1_rvalid), .m1_rdata_o(a_m1_rdata),
        .mem_req_o(a_mem_req), .mem_we_o(a_mem_we), .mem_addr_o(a_mem_addr),
        .mem_wdata_o(a_mem_wdata), .mem_rdata_i(mem_rdata)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(2), .MAX_BURST(4)) dut2 (
        .clk_i(clk), .rst_ni(rst_n),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_gnt_o(b_m0_gnt), .m0_rvalid_o(b_m0_rvalid), .m0_rdata_o(b_m0_rdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m1_gnt_o(b_m1_gnt), .m1_rvalid_o(b_m1_rvalid), .m1_rdata_o(b_m1_rdata),
        .mem_req_o(b_mem_req), .mem_we_o(b_mem_we), .mem_addr_o(b_mem_addr),
        .mem_wdata_o(b_mem_wdata), .mem_rdata_i(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        mem_rdata = 32'hA5A5_A5A5;
        idle();
        // Requests during reset must not reach any output
        m0_req = 1'b1; m0_addr = 32'h11; m0_wdata = 32'h22; m0_we = 1'b1;
        m1_req = 1'b1; m1_addr = 32'h33;
        #2;
        chk("rst_m0_gnt", {31'b0, a_m0_gnt}, 32'd0);
        chk("rst_m1_gnt", {31'b0, a_m1_gnt}, 32'd0);
        chk("rst_mem_req", {31'b0, a_mem_req}, 32'd0);
        chk("rst_mem_we", {31'b0, a_mem_we}, 32'd0);
        chk("rst_mem_addr", a_mem_addr, 32'd0);
        chk("rst_mem_wdata", a_mem_wdata, 32'd0);
        chk("rst_m0_rdata", a_m0_rdata, 32'd0);
        tick(); tick();
        idle();
        rst_n = 1'b1;
        #1;
        chk("idle_mem_req", {31'b0, a_mem_req}, 32'd0);
        tick();

        // Single read by m0, latency 1
        m0_req = 1'b1; m0_addr = 32'h100;
        #1;
        $display("T1 m0 read @0x100");
        chk("t1_m0_gnt", {31'b0, a_m0_gnt}, 32'd1);
        chk("t1_m1_gnt", {31'b0, a_m1_gnt}, 32'd0);
        chk("t1_mem_req", {31'b0, a_mem_req}, 32'd1);
        chk("t1_mem_addr", a_mem_addr, 32'h100);
        chk("t1_mem_we", {31'b0, a_mem_we}, 32'd0);
        tick();
        idle();
        mem_rdata = 32'hDEADBEEF;
        #1;
        chk("t1_m0_rvalid", {31'b0, a_m0_rvalid}, 32'd1);
        chk("t1_m0_rdata", a_m0_rdata, 32'hDEADBEEF);
        chk("t1_m1_rvalid", {31'b0, a_m1_rvalid}, 32'd0);
        chk("t1_m1_rdata", a_m1_rdata, 32'd0);
        chk("t1_idle_addr", a_mem_addr, 32'd0);
        tick();
        chk("t1_rvalid_once", {31'b0, a_m0_rvalid}, 32'd0);

        // Write by m1 produces no response
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h55;
        #1;
        $display("T2 m1 write @0x20");
        chk("t2_m1_gnt", {31'b0, a_m1_gnt}, 32'd1);
        chk("t2_m0_gnt", {31'b0, a_m0_gnt}, 32'd0);
        chk("t2_mem_we", {31'b0, a_mem_we}, 32'd1);
        chk("t2_mem_addr", a_mem_addr, 32'h20);
        chk("t2_mem_wdata", a_mem_wdata, 32'h55);
        tick();
        idle();
        #1;
        chk("t2_m0_rvalid", {31'b0, a_m0_rvalid}, 32'd0);
        chk("t2_m1_rvalid", {31'b0, a_m1_rvalid}, 32'd0);
        chk("t2_b_m1_rvalid", {31'b0, b_m1_rvalid}, 32'd0);
        tick();
        chk("t2_b_m1_rvalid2", {31'b0, b_m1_rvalid}, 32'd0);

        // m1 owns two grants, idle cycle clears the burst, tie goes to m0
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h30;
        #1;
        $display("T5 m1 burst of two, idle, tie");
        chk("t5_m1_gnt_a", {31'b0, a_m1_gnt}, 32'd1);
        tick();
        chk("t5_m1_gnt_b", {31'b0, a_m1_gnt}, 32'd1);
        tick();
        idle();
        tick();
        m0_req = 1'b1; m0_we = 1'b1; m1_req = 1'b1; m1_we = 1'b1;
        #1;
        chk("t5_tie_m0", {31'b0, a_m0_gnt}, 32'd1);
        chk("t5_tie_m1", {31'b0, a_m1_gnt}, 32'd0);
        tick();
        idle();
        tick();

        // m1 read, then reset pulse: response is dropped
        m1_req = 1'b1; m1_addr = 32'h40;
        #1;
        $display("T6 m1 read then reset pulse");
        chk("t6_m1_gnt", {31'b0, b_m1_gnt}, 32'd1);
        tick();
        rst_n = 1'b0;
        mem_rdata = 32'h1234_5678;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h8;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'hC;
        #1;
        chk("t6_rst_a_m1_rvalid", {31'b0, a_m1_rvalid}, 32'd0);
        chk("t6_rst_a_m1_rdata", a_m1_rdata, 32'd0);
        chk("t6_rst_a_m0_gnt", {31'b0, a_m0_gnt}, 32'd0);
        chk("t6_rst_a_mem_req", {31'b0, a_mem_req}, 32'd0);
        chk("t6_rst_b_mem_addr", b_mem_addr, 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("t6_b_m1_rvalid", {31'b0, b_m1_rvalid}, 32'd0);
        chk("t6_b_m1_rdata", b_m1_rdata, 32'd0);

        // Continuous contention from reset: m0 x4, m1 x4, m0
        $display("T3 contention sequence");
        for (int i = 0; i < 9; i++) begin
            logic exp0;
            exp0 = (i < 4) || (i == 8);
            chk($sformatf("t3_m0_gnt_%0d", i), {31'b0, a_m0_gnt}, {31'b0, exp0});
            chk($sformatf("t3_m1_gnt_%0d", i), {31'b0, a_m1_gnt}, {31'b0, ~exp0});
            tick();
        end
        idle();
        tick();

        // Back-to-back reads at latency 2
        $display("T4 back-to-back reads, latency 2");
        m0_req = 1'b1; m0_addr = 32'h0;
        #1;
        chk("t4_b_m0_gnt", {31'b0, b_m0_gnt}, 32'd1);
        tick();
        idle();
        m1_req = 1'b1; m1_addr = 32'h4;
        #1;
        chk("t4_b_m1_gnt", {31'b0, b_m1_gnt}, 32'd1);
        chk("t4_b_addr1", b_mem_addr, 32'h4);
        tick();
        idle();
        m0_req = 1'b1; m0_addr = 32'h8;
        mem_rdata = 32'hAAAA_0001;
        #1;
        chk("t4_b_addr2", b_mem_addr, 32'h8);
        chk("t4_c2_m0_rvalid", {31'b0, b_m0_rvalid}, 32'd1);
        chk("t4_c2_m0_rdata", b_m0_rdata, 32'hAAAA_0001);
        chk("t4_c2_m1_rvalid", {31'b0, b_m1_rvalid}, 32'd0);
        tick();
        idle();
        mem_rdata = 32'hBBBB_0002;
        #1;
        chk("t4_c3_m1_rvalid", {31'b0, b_m1_rvalid}, 32'd1);
        chk("t4_c3_m1_rdata", b_m1_rdata, 32'hBBBB_0002);
        chk("t4_c3_m0_rvalid", {31'b0, b_m0_rvalid}, 32'd0);
        chk("t4_c3_m0_rdata", b_m0_rdata, 32'd0);
        tick();
        mem_rdata = 32'hCCCC_0003;
        #1;
        chk("t4_c4_m0_rvalid", {31'b0, b_m0_rvalid}, 32'd1);
        chk("t4_c4_m0_rdata", b_m0_rdata, 32'hCCCC_0003);
        chk("t4_c4_m1_rvalid", {31'b0, b_m1_rvalid}, 32'd0);
        tick();
        chk("t4_c5_m0_rvalid", {31'b0, b_m0_rvalid}, 32'd0);
        chk("t4_c5_m1_rvalid", {31'b0, b_m1_rvalid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
